maria_bus_arbiter: RTL

MARIA_BUS_ARBITER -- requirements
Module: maria_bus_arbiter

---
 rtl/maria_bus_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/maria_bus_arbiter.sv
// maria_bus_arbiter: hands the CPU address bus to the Maria DMA sequencer
// with bus-turnaround settling and a per-line DMA ownership budget.
module maria_bus_arbiter #(
   parameter int SETTLE_TICKS = 1,
   parameter int LINE_BUDGET  = 400
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       mclk1,
   input  logic       pclk1,
   input  logic       RW,
   input  logic       lrc,
   input  logic       dma_req,
   input  logic       dma_done,
   output logic       halt_b,
   output logic       drive_AB,
   output logic       dma_grant,
   output logic       dma_abort,
   output logic [8:0] halted_ticks
);

   typedef enum logic [2:0] {
      IDLE,
      HALT_REQ,
      SETTLE_IN,
      OWN,
      SETTLE_OUT
   } state_t;

   localparam logic [8:0] BUDGET      = 9'(LINE_BUDGET);
   localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_TICKS - 1);
   localparam logic [8:0] SAT         = 9'h1ff;

   state_t     state;
   logic [1:0] settle_cnt;
   logic [8:0] budget;
   logic       rd_seen;

   logic       budget_inc;
   logic [8:0] budget_nxt;
   logic       exhausted;
   logic       budget_hit;
   logic       settling;
   logic       settle_done;
   logic       rd_strobe;

   assign budget_inc  = mclk1 && budget != SAT
                        && (state == SETTLE_IN || state == OWN);
   assign budget_nxt  = budget_inc ? budget + 9'd1 : budget;
   assign exhausted   = budget >= BUDGET;
   // A line reset on the same edge wipes the count, so it cannot hit.
   assign budget_hit  = state == OWN && !lrc && budget_nxt >= BUDGET;
   assign settling    = state == SETTLE_IN || state == SETTLE_OUT;
   assign settle_done = mclk1 && settle_cnt == SETTLE_LAST;
   assign rd_strobe   = pclk1 && RW;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state        <= IDLE;
         halt_b       <= 1'b1;
         drive_AB     <= 1'b0;
         dma_grant    <= 1'b0;
         dma_abort    <= 1'b0;
         budget       <= '0;
         halted_ticks <= '0;
         settle_cnt   <= '0;
         rd_seen      <= 1'b0;
      end else begin
         dma_abort <= 1'b0;
         budget    <= lrc ? '0 : budget_nxt;

         if (lrc)
            halted_ticks <= '0;
         else if (mclk1 && !halt_b && halted_ticks != SAT)
            halted_ticks <= halted_ticks + 9'd1;

         if (mclk1 && settling)
            settle_cnt <= settle_cnt + 2'd1;

         unique case (state)
            IDLE: begin
               if (mclk1 && dma_req && !exhausted) begin
                  state  <= HALT_REQ;
                  halt_b <= 1'b0;
               end
            end
            HALT_REQ: begin
               // A read-phase strobe is remembered until the next Maria tick.
               if (!dma_req) begin
                  state   <= IDLE;
                  halt_b  <= 1'b1;
                  rd_seen <= 1'b0;
               end else if (mclk1 && (rd_seen || rd_strobe)) begin
                  state      <= SETTLE_IN;
                  drive_AB   <= 1'b1;
                  rd_seen    <= 1'b0;
                  settle_cnt <= '0;
               end else if (rd_strobe) begin
                  rd_seen <= 1'b1;
               end
            end
            SETTLE_IN: begin
               if (settle_done) begin
                  state     <= OWN;
                  dma_grant <= 1'b1;
               end
            end
            OWN: begin
               if (budget_hit || dma_done) begin
                  state      <= SETTLE_OUT;
                  drive_AB   <= 1'b0;
                  dma_grant  <= 1'b0;
                  dma_abort  <= budget_hit;
                  settle_cnt <= '0;
               end
            end
            SETTLE_OUT: begin
               if (settle_done) begin
                  state  <= IDLE;
                  halt_b <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               halt_b    <= 1'b1;
               drive_AB  <= 1'b0;
               dma_grant <= 1'b0;
            end
         endcase
      end
   end

endmodule
